mc8051_mem_sched: RTL and testbench
===================================

Name: mc8051_mem_sched

Overview:
Memory-port scheduler for the mc8051 core. It shares the single external memory port between three pipeline requesters: S2 read, S3 read and S5 write. Their addresses and write data come from the core address/write-data mux. The block serialises the accesses, handles memory wait states with a timeout, and returns read data and completion pulses to the pipeline control.

Parameters:
- ADDR_W, 16: memory address width.
- DATA_W, 8: memory data width.
- TMO_CYC, 15: maximum wait cycles (i_mem_ready low) before an access is aborted.
- STARVE_LIM, 3: consecutive S2 wins over a pending S3 before S3 is promoted.

Ports:
- i_clk  in  1  core clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_s2_req  in  1  S2 read request; held high until o_s2_done.
- i_s2_addr  in  ADDR_W  S2 read address, from o_s2_mem_addr_d.
- i_s3_req  in  1  S3 read request; held high until o_s3_done.
- i_s3_addr  in  ADDR_W  S3 read address.
- i_s5_req  in  1  S5 write request; held high until o_s5_done.
- i_s5_addr  in  ADDR_W  S5 write address.
- i_s5_wdata  in  DATA_W  S5 write data, from o_mem_wdata.
- o_s2_done  out  1  one-cycle completion pulse for S2.
- o_s3_done  out  1  one-cycle completion pulse for S3.
- o_s5_done  out  1  one-cycle completion pulse for S5.
- o_s2_rdata  out  DATA_W  last S2 read data, held until the next S2 completion.
- o_s3_rdata  out  DATA_W  last S3 read data, held until the next S3 completion.
- o_bus_err  out  1  high together with a done pulse when that access timed out.
- o_mem_req  out  1  memory access strobe.
- o_mem_we  out  1  1 = write, 0 = read.
- o_mem_addr  out  ADDR_W  registered memory address.
- o_mem_wdata  out  DATA_W  registered write data.
- i_mem_ready  in  1  access complete this cycle.
- i_mem_rdata  in  DATA_W  read data, valid when i_mem_ready = 1.

Behaviour:
- Reset values: every output 0; state IDLE; wait counter 0; starve counter 0.
- State machine: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE with any request pending:
  - Pick a winner.
  - Register o_mem_addr, o_mem_we, o_mem_wdata and the grant id.
  - o_mem_req = 1 from the next cycle. Go to ACCESS.
- Priority, fixed: S5 > S3-promoted > S2 > S3.
  - S5 goes first so an older write always lands before a younger read.
  - S3 is promoted when the starve counter equals STARVE_LIM.
- Starve counter:
  - Increments when S2 wins while i_s3_req = 1.
  - Clears when S3 wins or i_s3_req = 0.
  - Saturates at STARVE_LIM.
- ACCESS:
  - o_mem_req, address and data stay stable.
  - The wait counter increments each cycle with i_mem_ready = 0.
  - i_mem_ready = 1: deassert o_mem_req next cycle. On a read, capture i_mem_rdata into the granted requester's rdata register. Go to DONE.
  - Wait counter reaches TMO_CYC with i_mem_ready still 0: deassert o_mem_req, set the timeout flag, go to DONE. The rdata register is not updated.
- DONE:
  - Pulse the granted o_sX_done for exactly one cycle.
  - o_bus_err equals the timeout flag in that cycle, 0 otherwise.
  - Clear the wait counter and timeout flag. Go to IDLE.
- Latency: with zero wait states, request sampled in cycle N gives o_mem_req in N+1, ready in N+1, done in N+2. Minimum 3 cycles per access.
- The requester drops req in the cycle after done. A req still high in IDLE is treated as a new request.
- Simultaneous events:
  - Requests arriving during ACCESS/DONE wait for IDLE.
  - A req deasserted during ACCESS does not abort the access; its done still pulses.
- Address wrap and width are pass-through; no arithmetic is performed on addresses.
- Reset mid-access clears all state immediately: o_mem_req = 0, no done pulse.
- An i_mem_ready seen in IDLE or DONE is ignored.

Decomposition:
- Shared package (global_param.v): state encodings MS_IDLE, MS_ACCESS, MS_DONE and grant ids GNT_S2, GNT_S3, GNT_S5.
- One natural sub-module: mc8051_mem_prio. It is the combinational priority picker, taking the request vector and the starve flag and returning a one-hot grant.
- Wait and starve counters and the FSM stay in the top level.

Test Plan:
- Single S2 read to 16'h0040, ready immediately, rdata 8'hA5 -> o_mem_req for 1 cycle with we = 0, o_s2_done at N+2, o_s2_rdata = 8'hA5.
- S2, S3 and S5 requested in the same cycle (S5 write 8'h3C to 16'h0081) -> service order S5, S2, S3; one done pulse each; o_mem_we = 1 only on the first access.
- S2 re-requests continuously with S3 pending, STARVE_LIM = 3 -> S2 wins 3 times, S3 wins the 4th arbitration.
- i_mem_ready held low -> after 15 wait cycles o_mem_req = 0; done pulses with o_bus_err = 1; o_sX_rdata keeps its previous value.
- 2 wait states on an S3 read of 16'h1234 -> address stable throughout, done at N+4, rdata captured from the ready cycle only.
- i_rst_n low during ACCESS -> all outputs 0 at once; after release, a pending request restarts from IDLE with no spurious done.

Source files
------------

// File: rtl/mc8051_mem_sched_pkg.sv
// mc8051 memory scheduler: shared types.
// State encodings and one-hot grant ids.
package mc8051_mem_sched_pkg;

  typedef enum logic [1:0] {
    MS_IDLE   = 2'd0,
    MS_ACCESS = 2'd1,
    MS_DONE   = 2'd2
  } ms_state_e;

  // Grant vector bit order is {S5, S3, S2}.
  localparam logic [2:0] GNT_S2 = 3'b001;
  localparam logic [2:0] GNT_S3 = 3'b010;
  localparam logic [2:0] GNT_S5 = 3'b100;

endpackage

// File: rtl/mc8051_mem_sched_prio.sv
// mc8051 memory scheduler: priority picker.
// Fixed order S5 > S3-promoted > S2 > S3.
module mc8051_mem_prio
  import mc8051_mem_sched_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic       starve_i,
  output logic [2:0] gnt_o
);

  // One-hot grant; writes first so older stores land before reads.
  always_comb begin
    if (req_i[2]) begin
      gnt_o = GNT_S5;
    end else if (req_i[1] && starve_i) begin
      gnt_o = GNT_S3;
    end else if (req_i[0]) begin
      gnt_o = GNT_S2;
    end else if (req_i[1]) begin
      gnt_o = GNT_S3;
    end else begin
      gnt_o = '0;
    end
  end

endmodule

// File: rtl/mc8051_mem_sched.sv
// mc8051 memory scheduler: serialises S2/S3 reads
// and S5 writes onto the single memory port.
module mc8051_mem_sched
  import mc8051_mem_sched_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int TMO_CYC    = 15,
  parameter int STARVE_LIM = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_s2_req,
  input  logic [ADDR_W-1:0] i_s2_addr,
  input  logic              i_s3_req,
  input  logic [ADDR_W-1:0] i_s3_addr,
  input  logic              i_s5_req,
  input  logic [ADDR_W-1:0] i_s5_addr,
  input  logic [DATA_W-1:0] i_s5_wdata,
  output logic              o_s2_done,
  output logic              o_s3_done,
  output logic              o_s5_done,
  output logic [DATA_W-1:0] o_s2_rdata,
  output logic [DATA_W-1:0] o_s3_rdata,
  output logic              o_bus_err,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int WC_W = $clog2(TMO_CYC + 1);
  localparam int SC_W = $clog2(STARVE_LIM + 1);

  ms_state_e         state_q, state_d;
  logic [2:0]        gnt_q, gnt_d;
  logic [2:0]        req_vec, pick;
  logic [WC_W-1:0]   wait_q, wait_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic              tmo_q, tmo_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] s2_rd_q, s2_rd_d;
  logic [DATA_W-1:0] s3_rd_q, s3_rd_d;
  logic              starve_hit, wait_last;

  assign req_vec    = {i_s5_req, i_s3_req, i_s2_req};
  assign starve_hit = (starve_q == SC_W'(STARVE_LIM));
  assign wait_last  = (wait_q == WC_W'(TMO_CYC - 1));

  mc8051_mem_prio u_prio (
    .req_i    (req_vec),
    .starve_i (starve_hit),
    .gnt_o    (pick)
  );

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= MS_IDLE;
      gnt_q    <= '0;
      wait_q   <= '0;
      starve_q <= '0;
      tmo_q    <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      s2_rd_q  <= '0;
      s3_rd_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      wait_q   <= wait_d;
      starve_q <= starve_d;
      tmo_q    <= tmo_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      s2_rd_q  <= s2_rd_d;
      s3_rd_q  <= s3_rd_d;
    end
  end

  // Next state: IDLE -> ACCESS -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MS_IDLE:   if (|req_vec) state_d = MS_ACCESS;
      MS_ACCESS: if (i_mem_ready || wait_last) state_d = MS_DONE;
      MS_DONE:   state_d = MS_IDLE;
      default:   state_d = MS_IDLE;
    endcase
  end

  // Grant capture, wait/starve counters, read data capture.
  always_comb begin
    gnt_d    = gnt_q;
    wait_d   = wait_q;
    starve_d = starve_q;
    tmo_d    = tmo_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    s2_rd_d  = s2_rd_q;
    s3_rd_d  = s3_rd_q;
    if (!i_s3_req) starve_d = '0;
    unique case (state_q)
      MS_IDLE: begin
        if (|req_vec) begin
          gnt_d = pick;
          req_d = 1'b1;
          we_d  = pick[2];
          unique case (1'b1)
            pick[2]: begin
              addr_d  = i_s5_addr;
              wdata_d = i_s5_wdata;
            end
            pick[1]: addr_d = i_s3_addr;
            default: addr_d = i_s2_addr;
          endcase
          if (pick[1]) begin
            starve_d = '0;
          end else if (pick[0] && i_s3_req && !starve_hit) begin
            starve_d = starve_q + SC_W'(1);
          end
        end
      end
      MS_ACCESS: begin
        if (i_mem_ready) begin
          req_d = 1'b0;
          if (!we_q && gnt_q == GNT_S2) s2_rd_d = i_mem_rdata;
          if (!we_q && gnt_q == GNT_S3) s3_rd_d = i_mem_rdata;
        end else begin
          wait_d = wait_q + WC_W'(1);
          if (wait_last) begin
            req_d = 1'b0;
            tmo_d = 1'b1;
          end
        end
      end
      MS_DONE: begin
        wait_d = '0;
        tmo_d  = 1'b0;
      end
      default: ;
    endcase
  end

  // Done pulses decode from DONE plus the held grant.
  always_comb begin
    o_s2_done   = (state_q == MS_DONE) && (gnt_q == GNT_S2);
    o_s3_done   = (state_q == MS_DONE) && (gnt_q == GNT_S3);
    o_s5_done   = (state_q == MS_DONE) && (gnt_q == GNT_S5);
    o_bus_err   = (state_q == MS_DONE) && tmo_q;
    o_mem_req   = req_q;
    o_mem_we    = we_q;
    o_mem_addr  = addr_q;
    o_mem_wdata = wdata_q;
    o_s2_rdata  = s2_rd_q;
    o_s3_rdata  = s3_rd_q;
  end

endmodule

// File: tb/tb_mc8051_mem_sched.sv
// Scoreboard bench for mc8051_mem_sched.
// Transaction model predicts service order and done results.
module tb_mc8051_mem_sched;

  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int TMO = 15;
  localparam int LIM = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_s2_req = 1'b0, i_s3_req = 1'b0, i_s5_req = 1'b0;
  logic [AW-1:0] i_s2_addr = '0, i_s3_addr = '0, i_s5_addr = '0;
  logic [DW-1:0] i_s5_wdata = '0;
  logic          o_s2_done, o_s3_done, o_s5_done, o_bus_err;
  logic [DW-1:0] o_s2_rdata, o_s3_rdata;
  logic          o_mem_req, o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic          i_mem_ready;
  logic [DW-1:0] i_mem_rdata;

  always #5 clk = ~clk;

  mc8051_mem_sched dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_s2_req    (i_s2_req),
    .i_s2_addr   (i_s2_addr),
    .i_s3_req    (i_s3_req),
    .i_s3_addr   (i_s3_addr),
    .i_s5_req    (i_s5_req),
    .i_s5_addr   (i_s5_addr),
    .i_s5_wdata  (i_s5_wdata),
    .o_s2_done   (o_s2_done),
    .o_s3_done   (o_s3_done),
    .o_s5_done   (o_s5_done),
    .o_s2_rdata  (o_s2_rdata),
    .o_s3_rdata  (o_s3_rdata),
    .o_bus_err   (o_bus_err),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ready (i_mem_ready),
    .i_mem_rdata (i_mem_rdata)
  );

  typedef struct {
    int            who;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } acc_t;

  typedef struct {
    int            who;
    logic          err;
    logic [DW-1:0] rd;
  } dn_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } item_t;

  item_t q2[$], q3[$], q5[$];
  acc_t  exp_acc[$];
  dn_t   exp_dn[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  int force_w = -1;
  logic [DW-1:0] force_d = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  // Transaction-level arbitration over the queued requests.
  task automatic model_round();
    int n2 = q2.size();
    int n3 = q3.size();
    int n5 = q5.size();
    int i2 = 0, i3 = 0, i5 = 0, st = 0;
    acc_t a;
    while (i2 < n2 || i3 < n3 || i5 < n5) begin
      bit p2 = (i2 < n2);
      bit p3 = (i3 < n3);
      bit p5 = (i5 < n5);
      if (!p3) st = 0;
      if (p5) begin
        a = '{who: 2, we: 1'b1, addr: q5[i5].addr, wd: q5[i5].wd};
        i5++;
      end else if (p3 && st == LIM) begin
        a = '{who: 1, we: 1'b0, addr: q3[i3].addr, wd: 8'h00};
        i3++;
        st = 0;
      end else if (p2) begin
        a = '{who: 0, we: 1'b0, addr: q2[i2].addr, wd: 8'h00};
        i2++;
        st = p3 ? ((st < LIM) ? st + 1 : LIM) : 0;
      end else begin
        a = '{who: 1, we: 1'b0, addr: q3[i3].addr, wd: 8'h00};
        i3++;
        st = 0;
      end
      exp_acc.push_back(a);
    end
  endtask

  // Requesters: hold req while work is queued, advance on done.
  task automatic step();
    @(negedge clk);
    if (o_s2_done && q2.size() != 0) q2.delete(0);
    if (o_s3_done && q3.size() != 0) q3.delete(0);
    if (o_s5_done && q5.size() != 0) q5.delete(0);
    i_s2_req = (q2.size() != 0);
    i_s3_req = (q3.size() != 0);
    i_s5_req = (q5.size() != 0);
    if (q2.size() != 0) i_s2_addr = q2[0].addr;
    if (q3.size() != 0) i_s3_addr = q3[0].addr;
    if (q5.size() != 0) begin
      i_s5_addr  = q5[0].addr;
      i_s5_wdata = q5[0].wd;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((q2.size() + q3.size() + q5.size() +
            exp_acc.size() + exp_dn.size()) != 0) begin
      step();
      n++;
      if (n > budget) begin
        fail("round_timeout");
        q2.delete();
        q3.delete();
        q5.delete();
        exp_acc.delete();
        exp_dn.delete();
      end
    end
    repeat (2) step();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_req"}, o_mem_req, 0);
    chk({tag, "_mem_we"}, o_mem_we, 0);
    chk({tag, "_mem_addr"}, o_mem_addr, 0);
    chk({tag, "_mem_wdata"}, o_mem_wdata, 0);
    chk({tag, "_dones"}, {o_s5_done, o_s3_done, o_s2_done}, 0);
    chk({tag, "_bus_err"}, o_bus_err, 0);
    chk({tag, "_s2_rdata"}, o_s2_rdata, 0);
    chk({tag, "_s3_rdata"}, o_s3_rdata, 0);
  endtask

  // Memory responder: checks each access, predicts its done.
  initial begin
    acc_t cur;
    int wcnt = 0, wtgt = 0;
    logic prev_req = 1'b0;
    logic [DW-1:0] rd_val = '0;
    logic [DW-1:0] exp_rd [3];
    logic any_done;
    dn_t d;
    for (int i = 0; i < 3; i++) exp_rd[i] = '0;
    cur = '{who: 0, we: 1'b0, addr: '0, wd: '0};
    i_mem_ready = 1'b0;
    i_mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 1'b0;
        i_mem_ready = 1'b0;
        exp_acc.delete();
        exp_dn.delete();
        for (int i = 0; i < 3; i++) exp_rd[i] = '0;
      end else begin
        any_done = o_s2_done | o_s3_done | o_s5_done;
        if (any_done || (prev_req && !o_mem_req))
          chk("done_timing", any_done, prev_req && !o_mem_req);
        if (o_mem_req && !prev_req) begin
          if (exp_acc.size() == 0) begin
            fail("unexpected_access");
            cur = '{who: 0, we: o_mem_we, addr: o_mem_addr, wd: '0};
          end else begin
            cur = exp_acc.pop_front();
          end
          chk("acc_we", o_mem_we, cur.we);
          chk("acc_addr", o_mem_addr, cur.addr);
          if (cur.we) chk("acc_wdata", o_mem_wdata, cur.wd);
          if (force_w >= 0) begin
            wtgt = force_w;
            rd_val = force_d;
          end else begin
            wtgt = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
            rd_val = 8'($urandom);
          end
          wcnt = 0;
          if (wtgt >= TMO) begin
            d = '{who: cur.who, err: 1'b1, rd: exp_rd[cur.who]};
          end else begin
            if (!cur.we) exp_rd[cur.who] = rd_val;
            d = '{who: cur.who, err: 1'b0, rd: exp_rd[cur.who]};
          end
          exp_dn.push_back(d);
        end
        if (o_mem_req) begin
          if (prev_req) begin
            chk("addr_stable", o_mem_addr, cur.addr);
            chk("we_stable", o_mem_we, cur.we);
          end
          i_mem_ready = (wcnt == wtgt);
          i_mem_rdata = (wcnt == wtgt) ? rd_val : 8'($urandom);
          wcnt++;
        end else begin
          if (prev_req)
            chk("req_cycles", wcnt, (wtgt >= TMO) ? TMO : wtgt + 1);
          i_mem_ready = 1'($urandom_range(0, 1));
          i_mem_rdata = 8'($urandom);
        end
        prev_req = o_mem_req;
      end
    end
  end

  // Done monitor: pops the scoreboard on every completion pulse.
  initial begin
    dn_t d;
    logic [2:0] dv;
    forever begin
      @(negedge clk);
      dv = {o_s5_done, o_s3_done, o_s2_done};
      if (rst_n && dv != 3'b000) begin
        last_done_cyc = cyc;
        chk("done_onehot", $countones(dv), 1);
        if (exp_dn.size() == 0) begin
          fail("unexpected_done");
        end else begin
          d = exp_dn.pop_front();
          chk("done_who", dv, 32'(1) << d.who);
          chk("bus_err", o_bus_err, d.err);
          if (d.who == 0) chk("s2_rdata", o_s2_rdata, d.rd);
          if (d.who == 1) chk("s3_rdata", o_s3_rdata, d.rd);
        end
      end else if (rst_n && o_bus_err) begin
        fail("bus_err_without_done");
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, n;
    item_t it;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) step();
    chk("idle_after_reset", o_mem_req, 0);

    // Single zero-wait S2 read.
    force_w = 0;
    force_d = 8'hA5;
    q2.push_back('{addr: 16'h0040, wd: 8'h00});
    model_round();
    step();
    c = cyc;
    wait_idle(50);
    chk("s2_latency", last_done_cyc - c, 2);
    chk("s2_rdata_a5", o_s2_rdata, 8'hA5);

    // S3 read with two wait states.
    force_w = 2;
    force_d = 8'h77;
    q3.push_back('{addr: 16'h1234, wd: 8'h00});
    model_round();
    step();
    c = cyc;
    wait_idle(50);
    chk("s3_latency", last_done_cyc - c, 4);

    // S3 read that never sees ready.
    force_w = 99;
    q3.push_back('{addr: 16'h2222, wd: 8'h00});
    model_round();
    step();
    c = cyc;
    wait_idle(60);
    chk("tmo_latency", last_done_cyc - c, TMO + 1);
    chk("s3_rdata_kept", o_s3_rdata, 8'h77);

    // All three at once, then S2 starving S3.
    force_w = -1;
    q2.push_back('{addr: 16'h0010, wd: 8'h00});
    q3.push_back('{addr: 16'h0020, wd: 8'h00});
    q5.push_back('{addr: 16'h0081, wd: 8'h3C});
    model_round();
    wait_idle(200);
    for (int i = 0; i < 5; i++)
      q2.push_back('{addr: 16'(16'h0100 + i), wd: 8'h00});
    q3.push_back('{addr: 16'h0300, wd: 8'h00});
    model_round();
    wait_idle(300);

    // Reset in the middle of an access.
    force_w = 40;
    q2.push_back('{addr: 16'h0BEE, wd: 8'h00});
    model_round();
    step();
    n = 0;
    while (!o_mem_req && n < 10) begin
      step();
      n++;
    end
    chk("rst_test_started", o_mem_req, 1);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    repeat (2) @(negedge clk);
    force_w = 1;
    force_d = 8'h5A;
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_round();
    wait_idle(50);
    chk("s2_after_rst", o_s2_rdata, 8'h5A);

    // Random rounds.
    force_w = -1;
    for (int r = 0; r < 40; r++) begin
      int n2 = $urandom_range(0, 3);
      int n3 = $urandom_range(0, 3);
      int n5 = $urandom_range(0, 3);
      if (n2 + n3 + n5 == 0) n2 = 1;
      for (int i = 0; i < n2; i++) begin
        it.addr = 16'($urandom);
        it.wd = 8'h00;
        q2.push_back(it);
      end
      for (int i = 0; i < n3; i++) begin
        it.addr = 16'($urandom);
        it.wd = 8'h00;
        q3.push_back(it);
      end
      for (int i = 0; i < n5; i++) begin
        it.addr = 16'($urandom);
        it.wd = 8'($urandom);
        q5.push_back(it);
      end
      model_round();
      wait_idle(400);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
